// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches 14-bit micro-words from an external synchronous ROM,
// expands them into the 25-bit datapath control word and sequences micro-addresses.
module microcode_sequencer #(
    parameter int UADDR_W = 9,
    parameter int UWORD_W = 14,
    parameter int CW_W    = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         opcode_i,
    input  logic               flag_zero_i,
    input  logic               flag_carry_i,
    input  logic               flag_rem_i,
    input  logic               mem_ready_i,
    input  logic               resume_i,
    output logic [UADDR_W-1:0] uaddr_o,
    input  logic [UWORD_W-1:0] uword_i,
    output logic [CW_W-1:0]    ctrl_o,
    output logic               ctrl_valid_o,
    output logic               halted_o
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] CLS_ALU    = 2'd0;
    localparam logic [1:0] CLS_MOVE   = 2'd1;
    localparam logic [1:0] CLS_MEM    = 2'd2;
    localparam logic [1:0] CLS_BRANCH = 2'd3;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_ENABLE = 2'd2;
    localparam logic [2:0] MEM_READ   = 3'd1;
    localparam logic [2:0] MEM_WRITE  = 3'd2;

    state_t               state_r;
    state_t               state_s;
    logic [UADDR_W-1:0]   upc_r;
    logic [UADDR_W-1:0]   upc_s;
    logic                 dispatch_pending_r;
    logic                 dispatch_pending_s;
    logic [CW_W-1:0]      ctrl_hold_r;
    logic [CW_W-1:0]      ctrl_dec_s;
    logic [UADDR_W-1:0]   uaddr_s;
    logic [1:0]           cls_s;
    logic                 branch_taken_s;

    // Expand one micro-word into the packed control word; branches expand to all-zero.
    function automatic logic [24:0] decode_uword(input logic [13:0] w);
        logic [3:0]      alu_op;
        logic            alu_en;
        logic [2:0]      mem_op;
        logic            dws;
        logic            bus;
        logic [3:0][1:0] reg_f;
        logic [2:0]      ir_op;
        logic            rst_b;
        logic            halt_b;
        logic            cul;
        logic            ni;
        alu_op = 4'd0;
        alu_en = 1'b0;
        mem_op = 3'd0;
        dws    = 1'b0;
        bus    = 1'b0;
        reg_f  = 8'd0;
        ir_op  = 3'd0;
        rst_b  = 1'b0;
        halt_b = 1'b0;
        cul    = 1'b0;
        ni     = 1'b0;
        case (w[13:12])
            CLS_ALU: begin
                if (w[11:8] > 4'd12) begin
                    alu_op = 4'd0;
                    alu_en = 1'b0;
                end else begin
                    alu_op = w[11:8];
                    alu_en = 1'b1;
                end
                // Source first so a shared src/dst register ends up as LOAD.
                reg_f[w[5:4]] = REG_ENABLE;
                reg_f[w[7:6]] = REG_LOAD;
            end
            CLS_MOVE: begin
                if (w[7]) reg_f[w[11:10]] = REG_ENABLE;
                if (w[6]) reg_f[w[9:8]]   = REG_LOAD;
                ir_op  = (w[5:3] > 3'd4) ? 3'd0 : w[5:3];
                ni     = w[2];
                halt_b = w[1];
                rst_b  = w[0];
            end
            CLS_MEM: begin
                mem_op = (w[11:10] == 2'd3) ? 3'd0 : {1'b0, w[11:10]};
                bus    = w[9];
                dws    = w[8];
                if (w[5] && (mem_op == MEM_READ))  reg_f[w[7:6]] = REG_LOAD;
                if (w[5] && (mem_op == MEM_WRITE)) reg_f[w[7:6]] = REG_ENABLE;
                ir_op  = (w[4:2] > 3'd4) ? 3'd0 : w[4:2];
                cul    = w[0];
            end
            default: begin
                alu_op = 4'd0;
            end
        endcase
        return {alu_op, alu_en, mem_op, dws, bus,
                reg_f[0], reg_f[1], reg_f[2], reg_f[3],
                ir_op, rst_b, halt_b, cul, ni};
    endfunction

    function automatic logic cond_met(input logic [1:0] cond, input logic z,
                                      input logic c, input logic r);
        case (cond)
            2'd0:    return 1'b1;
            2'd1:    return z;
            2'd2:    return c;
            default: return r;
        endcase
    endfunction

    // Word decode and branch evaluation for the word currently presented by the ROM.
    always_comb begin
        cls_s          = uword_i[13:12];
        ctrl_dec_s     = decode_uword(uword_i);
        branch_taken_s = (cls_s == CLS_BRANCH) &&
                         cond_met(uword_i[11:10], flag_zero_i, flag_carry_i, flag_rem_i);
        uaddr_s        = dispatch_pending_r ? {opcode_i, 1'b0} : upc_r;
    end

    // Next-state and micro-PC sequencing.
    always_comb begin
        state_s            = state_r;
        upc_s              = upc_r;
        dispatch_pending_s = dispatch_pending_r;
        case (state_r)
            ST_FETCH: begin
                upc_s              = uaddr_s;
                dispatch_pending_s = 1'b0;
                state_s            = ST_EXEC;
            end
            ST_EXEC: begin
                if ((cls_s == CLS_MOVE) && uword_i[0]) begin
                    upc_s              = 9'd0;
                    dispatch_pending_s = 1'b0;
                    state_s            = ST_FETCH;
                end else if ((cls_s == CLS_MOVE) && uword_i[1]) begin
                    state_s = ST_HALTED;
                end else begin
                    if (branch_taken_s) begin
                        upc_s = uword_i[8:0];
                    end else begin
                        upc_s = upc_r + 9'd1;
                    end
                    if ((cls_s == CLS_MOVE) && uword_i[2]) begin
                        dispatch_pending_s = 1'b1;
                    end else begin
                        dispatch_pending_s = dispatch_pending_r;
                    end
                    if ((cls_s == CLS_MEM) && uword_i[1] && !mem_ready_i) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ready_i) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    upc_s   = upc_r + 9'd1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_FETCH;
            upc_r              <= 9'd0;
            dispatch_pending_r <= 1'b0;
        end else begin
            state_r            <= state_s;
            upc_r              <= upc_s;
            dispatch_pending_r <= dispatch_pending_s;
        end
    end

    // Capture the executing control word so it stays stable through memory waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_hold_r <= 25'd0;
        end else if (state_r == ST_EXEC) begin
            ctrl_hold_r <= ctrl_dec_s;
        end else begin
            ctrl_hold_r <= ctrl_hold_r;
        end
    end

    assign uaddr_o      = uaddr_s;
    assign ctrl_o       = (state_r == ST_EXEC) ? ctrl_dec_s :
                          (state_r == ST_WAIT) ? ctrl_hold_r : 25'd0;
    assign ctrl_valid_o = ((state_r == ST_EXEC) && (cls_s != CLS_BRANCH)) ||
                          (state_r == ST_WAIT);
    assign halted_o     = (state_r == ST_HALTED);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed vector table, hand-written corner sequences
// and a randomized run checked against a transaction-level reference model.
module tb_microcode_sequencer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  opcode;
    logic        fz, fc, fr, mem_ready, resume;
    logic [8:0]  uaddr;
    logic [13:0] uword;
    logic [24:0] ctrl;
    logic        ctrl_valid, halted;

    logic        nx_rst_n, nx_fz, nx_fc, nx_fr, nx_mem_ready, nx_resume;
    logic [7:0]  nx_opcode;
    logic [13:0] rom [512];

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [13:0] w;
        logic [24:0] c;
        logic        v;
    } vec_t;
    vec_t tbl [11];

    microcode_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode),
        .flag_zero_i  (fz),
        .flag_carry_i (fc),
        .flag_rem_i   (fr),
        .mem_ready_i  (mem_ready),
        .resume_i     (resume),
        .uaddr_o      (uaddr),
        .uword_i      (uword),
        .ctrl_o       (ctrl),
        .ctrl_valid_o (ctrl_valid),
        .halted_o     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: address sampled at the clock edge, data valid afterwards.
    initial uword = 14'd0;
    always @(posedge clk) uword <= rom[uaddr];

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply the staged inputs on the falling edge and settle before sampling.
    task automatic cyc();
        @(negedge clk);
        rst_n     = nx_rst_n;
        opcode    = nx_opcode;
        fz        = nx_fz;
        fc        = nx_fc;
        fr        = nx_fr;
        mem_ready = nx_mem_ready;
        resume    = nx_resume;
        #1;
    endtask

    task automatic fetch_chk(input string nm, input logic [8:0] a);
        cyc();
        chk({nm, "_uaddr"}, 32'(uaddr), 32'(a));
        chk({nm, "_valid"}, 32'(ctrl_valid), 32'd0);
        chk({nm, "_ctrl"}, 32'(ctrl), 32'd0);
        chk({nm, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic exec_chk(input string nm, input logic [24:0] c, input logic v);
        cyc();
        chk({nm, "_ctrl"}, 32'(ctrl), 32'(c));
        chk({nm, "_valid"}, 32'(ctrl_valid), 32'(v));
        chk({nm, "_halted"}, 32'(halted), 32'd0);
    endtask

    task automatic halted_chk(input string nm);
        cyc();
        chk({nm, "_halted"}, 32'(halted), 32'd1);
        chk({nm, "_valid"}, 32'(ctrl_valid), 32'd0);
        chk({nm, "_ctrl"}, 32'(ctrl), 32'd0);
    endtask

    task automatic rand_nx();
        nx_opcode    = 8'($urandom);
        nx_fz        = 1'($urandom_range(0, 1));
        nx_fc        = 1'($urandom_range(0, 1));
        nx_fr        = 1'($urandom_range(0, 1));
        nx_mem_ready = ($urandom_range(0, 2) != 0);
        nx_resume    = ($urandom_range(0, 3) == 0);
    endtask

    task automatic hold_reset();
        nx_rst_n = 1'b0;
        cyc();
        cyc();
        nx_rst_n = 1'b1;
    endtask

    // Reference expansion: each register field placed at its bit position by arithmetic.
    function automatic logic [24:0] ref_ctrl(input logic [13:0] w);
        int regs [4];
        int alu, en, mem, dws, bus, ir, rstb, hlt, cul, ni;
        logic [24:0] c;
        for (int i = 0; i < 4; i++) regs[i] = 0;
        alu = 0; en = 0; mem = 0; dws = 0; bus = 0; ir = 0;
        rstb = 0; hlt = 0; cul = 0; ni = 0;
        case (w[13:12])
            2'd0: begin
                alu = int'(w[11:8]);
                en  = 1;
                if (alu > 12) begin alu = 0; en = 0; end
                regs[w[5:4]] = 2;
                regs[w[7:6]] = 1;
            end
            2'd1: begin
                if (w[7]) regs[w[11:10]] = 2;
                if (w[6]) regs[w[9:8]] = 1;
                ir = int'(w[5:3]);
                if (ir > 4) ir = 0;
                ni = int'(w[2]); hlt = int'(w[1]); rstb = int'(w[0]);
            end
            2'd2: begin
                mem = int'(w[11:10]);
                if (mem == 3) mem = 0;
                bus = int'(w[9]); dws = int'(w[8]);
                if (w[5] && mem == 1) regs[w[7:6]] = 1;
                if (w[5] && mem == 2) regs[w[7:6]] = 2;
                ir = int'(w[4:2]);
                if (ir > 4) ir = 0;
                cul = int'(w[0]);
            end
            default: ;
        endcase
        c = 25'(alu * (1 << 21) + en * (1 << 20) + mem * (1 << 17) + dws * (1 << 16)
               + bus * (1 << 15) + ir * (1 << 4) + rstb * 8 + hlt * 4 + cul * 2 + ni);
        for (int i = 0; i < 4; i++) c = c + 25'(regs[i] * (1 << (13 - 2 * i)));
        return c;
    endfunction

    // Walk micro-ops one transaction at a time, predicting addresses and outputs.
    task automatic run_random(input int nops);
        logic [8:0]  m_upc;
        logic        m_dp;
        logic [8:0]  a;
        logic [13:0] w;
        logic [24:0] c;
        logic        taken;
        m_upc = 9'd0;
        m_dp  = 1'b0;
        for (int op = 0; op < nops; op++) begin
            rand_nx();
            cyc();
            a = m_dp ? {opcode, 1'b0} : m_upc;
            chk("rnd_fetch_addr", 32'(uaddr), 32'(a));
            chk("rnd_fetch_valid", 32'(ctrl_valid), 32'd0);
            chk("rnd_fetch_ctrl", 32'(ctrl), 32'd0);
            m_upc = a;
            m_dp  = 1'b0;
            w     = rom[a];
            c     = ref_ctrl(w);
            rand_nx();
            cyc();
            chk("rnd_exec_ctrl", 32'(ctrl), 32'(c));
            chk("rnd_exec_valid", 32'(ctrl_valid), 32'(w[13:12] != 2'd3));
            chk("rnd_exec_halted", 32'(halted), 32'd0);
            if (w[13:12] == 2'd1 && w[0]) begin
                m_upc = 9'd0;
            end else if (w[13:12] == 2'd1 && w[1]) begin
                for (int k = 0; k < 20; k++) begin
                    rand_nx();
                    if (k >= 4) nx_resume = 1'b1;
                    cyc();
                    chk("rnd_halt_halted", 32'(halted), 32'd1);
                    chk("rnd_halt_valid", 32'(ctrl_valid), 32'd0);
                    chk("rnd_halt_ctrl", 32'(ctrl), 32'd0);
                    if (resume) break;
                end
                m_upc = m_upc + 9'd1;
            end else begin
                case (w[11:10])
                    2'd0:    taken = 1'b1;
                    2'd1:    taken = fz;
                    2'd2:    taken = fc;
                    default: taken = fr;
                endcase
                taken = taken && (w[13:12] == 2'd3);
                m_upc = taken ? w[8:0] : m_upc + 9'd1;
                if (w[13:12] == 2'd1 && w[2]) m_dp = 1'b1;
                if (w[13:12] == 2'd2 && w[1] && !mem_ready) begin
                    for (int k = 0; k < 20; k++) begin
                        rand_nx();
                        if (k >= 5) nx_mem_ready = 1'b1;
                        cyc();
                        chk("rnd_wait_ctrl", 32'(ctrl), 32'(c));
                        chk("rnd_wait_valid", 32'(ctrl_valid), 32'd1);
                        if (mem_ready) break;
                    end
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = '{14'h11C0, 25'h0004800, 1'b1};
        tbl[1]  = '{14'h01B0, 25'h0300300, 1'b1};
        tbl[2]  = '{14'h0E00, 25'h0002000, 1'b1};
        tbl[3]  = '{14'h0C50, 25'h1900800, 1'b1};
        tbl[4]  = '{14'h18A0, 25'h0000440, 1'b1};
        tbl[5]  = '{14'h1370, 25'h0000080, 1'b1};
        tbl[6]  = '{14'h2769, 25'h0038822, 1'b1};
        tbl[7]  = '{14'h2C3C, 25'h0000000, 1'b1};
        tbl[8]  = '{14'h28E0, 25'h0040100, 1'b1};
        tbl[9]  = '{14'h35F0, 25'h0000000, 1'b0};
        tbl[10] = '{14'h3855, 25'h0000000, 1'b0};

        nx_rst_n = 1'b0; nx_opcode = 8'd0; nx_fz = 1'b0; nx_fc = 1'b0; nx_fr = 1'b0;
        nx_mem_ready = 1'b1; nx_resume = 1'b0;
        rst_n = 1'b0; opcode = 8'd0; fz = 1'b0; fc = 1'b0; fr = 1'b0;
        mem_ready = 1'b1; resume = 1'b0;
        for (int i = 0; i < 512; i++) rom[i] = 14'h1000;
        for (int i = 0; i < 11; i++) rom[i] = tbl[i].w;

        // Reset state, then the decode table executed from consecutive addresses.
        hold_reset();
        chk("rst_uaddr", 32'(uaddr), 32'd0);
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_valid", 32'(ctrl_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 11; i++) begin
            fetch_chk("tbl_fetch", 9'(i));
            exec_chk("tbl_exec", tbl[i].c, tbl[i].v);
        end
        fetch_chk("tbl_last_fetch", 9'd11);

        // Dispatch, memory wait, branches, wrap, halt/resume and reset-in-wait.
        for (int i = 0; i < 512; i++) rom[i] = 14'h1000;
        rom[9'h000] = 14'h1004;
        rom[9'h055] = 14'h24A2;
        rom[9'h056] = 14'h35F0;
        rom[9'h1F0] = 14'h35F0;
        rom[9'h1F1] = 14'h31FF;
        rom[9'h1FF] = 14'h0E10;
        rom[9'h007] = 14'h1002;
        rom[9'h008] = 14'h24A2;
        hold_reset();
        nx_opcode = 8'h2A;
        fetch_chk("disp_f0", 9'h000);
        exec_chk("disp_e0", 25'h0000001, 1'b1);
        fetch_chk("disp_f54", 9'h054);
        nx_opcode = 8'h11;
        exec_chk("disp_e54", 25'h0000000, 1'b1);
        fetch_chk("seq_f55", 9'h055);
        nx_mem_ready = 1'b0;
        exec_chk("wait_exec", 25'h0020200, 1'b1);
        exec_chk("wait_c1", 25'h0020200, 1'b1);
        exec_chk("wait_c2", 25'h0020200, 1'b1);
        nx_mem_ready = 1'b1;
        exec_chk("wait_c3", 25'h0020200, 1'b1);
        nx_fz = 1'b1;
        fetch_chk("wait_after_f56", 9'h056);
        exec_chk("br_taken_e", 25'h0000000, 1'b0);
        nx_fz = 1'b0;
        fetch_chk("br_taken_f", 9'h1F0);
        exec_chk("br_nt_e", 25'h0000000, 1'b0);
        fetch_chk("br_nt_f", 9'h1F1);
        exec_chk("br_always_e", 25'h0000000, 1'b0);
        fetch_chk("wrap_f1ff", 9'h1FF);
        exec_chk("wrap_illegal_alu", 25'h0003000, 1'b1);
        fetch_chk("wrap_f0", 9'h000);
        exec_chk("disp2_e0", 25'h0000001, 1'b1);
        nx_opcode = 8'h03;
        fetch_chk("disp2_f6", 9'h006);
        exec_chk("disp2_e6", 25'h0000000, 1'b1);
        fetch_chk("halt_f7", 9'h007);
        exec_chk("halt_e7", 25'h0000004, 1'b1);
        halted_chk("halt_h1");
        halted_chk("halt_h2");
        halted_chk("halt_h3");
        nx_resume = 1'b1;
        halted_chk("halt_resume");
        nx_resume = 1'b0;
        fetch_chk("resume_f8", 9'h008);
        nx_mem_ready = 1'b0;
        exec_chk("rstw_exec", 25'h0020200, 1'b1);
        exec_chk("rstw_wait", 25'h0020200, 1'b1);
        #2;
        nx_rst_n = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_ctrl", 32'(ctrl), 32'd0);
        chk("rstw_valid", 32'(ctrl_valid), 32'd0);
        chk("rstw_halted", 32'(halted), 32'd0);
        chk("rstw_uaddr", 32'(uaddr), 32'd0);
        cyc();
        nx_rst_n = 1'b1;
        nx_mem_ready = 1'b1;
        fetch_chk("rstw_first_fetch", 9'h000);

        // Randomized micro-program against the reference model.
        for (int i = 0; i < 512; i++) begin
            rom[i] = 14'($urandom);
            if (rom[i][13:12] == 2'd1) begin
                rom[i][1] = ($urandom_range(0, 15) == 0);
                rom[i][0] = ($urandom_range(0, 31) == 0);
            end
        end
        hold_reset();
        run_random(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
